tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
Round-robin arbiter that shares the single serial_transmitter between several byte sources, such as the keyboard control block and a status/echo source. It sits between the requesters and the transmitter's req/data/ack port. It latches the winning byte, sequences the transmitter handshake and returns a one-cycle ack to the winner. A watchdog frees the transmitter if its ack never arrives.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
DATA_W, 8, byte width per requester.
TIMEOUT, 1000000, cycles in SEND without s_ack before abort; 0 disables the watchdog.
TO_W, 20, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock (the 50 MHz domain shared with control/serial_transmitter).
rst_n  in  1  reset; asynchronous, active-low.
req  in  NUM_REQ  per-requester request; bit i is held high with data stable until ack[i].
data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
ack  out  NUM_REQ  one-cycle pulse to the served requester.
err  out  1  one-cycle pulse coincident with ack when the transfer was aborted by timeout.
s_req  out  1  request to serial_transmitter.
s_data  out  DATA_W  byte to serial_transmitter; registered, stable while s_req=1.
s_ack  in  1  transmitter acknowledge (pulse or level; only the first cycle high counts).
busy  out  1  high in SEND and GAP.
grant_id  out  clog2(NUM_REQ)  index of the current/last grant.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack=0, err=0, s_req=0, s_data=0, busy=0, grant_id=NUM_REQ-1 so that requester 0 wins first; timeout counter=0.
- All outputs are registered.
- State machine, IDLE -> SEND -> GAP -> IDLE:
  - IDLE: if any req bit is high, select the first set bit scanning from grant_id+1 upward with wrap (round-robin).
    - Next cycle: s_req=1, s_data=data[winner], grant_id=winner, busy=1, counter=0, state=SEND.
    - No req: remain in IDLE.
  - SEND: s_req and s_data are held constant.
    - On a cycle where s_ack=1: next cycle ack[grant_id]=1, s_req=0, state=GAP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: next cycle ack[grant_id]=1, err=1, s_req=0, state=GAP.
    - Else counter+1.
    - If s_ack and timeout coincide, s_ack wins (err=0).
  - GAP: exactly one cycle with s_req=0 and ack/err deasserted; then IDLE, busy=0.
    - GAP guarantees the transmitter sees s_req low between bytes and gives the requester a cycle to drop req.
- Latency:
  - req rising while IDLE in cycle t -> s_req=1 in t+1.
  - s_ack in cycle k -> ack in k+1.
  - Next s_req no earlier than k+3.
- Requester rule: deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new byte and arbitrated normally.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Changes on data or req of non-granted requesters during SEND are ignored. A requester dropping req mid-SEND does not cancel the transfer; its ack still pulses.
- s_ack outside SEND is ignored.
- rst_n asserted mid-transfer forces s_req=0 immediately (asynchronously); no ack is issued for the aborted byte.

Test Plan:
- Single request: req=2'b01, data[7:0]=8'h1C; transmitter acks 5 cycles after s_req -> s_req high from cycle 1, s_data=8'h1C, ack=2'b01 pulses one cycle after s_ack, grant_id=0, err=0.
- Contention: req=2'b11 (bytes 8'hAA, 8'h55) held and re-asserted after each ack for 4 transfers -> s_data sequence AA,55,AA,55; a GAP cycle with s_req=0 before each new s_req.
- First grant after reset: req=2'b10 then 2'b11 -> requester 1 is granted first (8'h55), then requester 0; with 2'b11 asserted simultaneously straight out of reset, requester 0 wins first.
- Timeout: TIMEOUT=16, s_ack tied low -> s_req drops after 16 SEND cycles; ack[grant_id] and err pulse together; next pending request is then served.
- s_ack coinciding with the last timeout cycle -> ack pulses with err=0.
- Reset mid-SEND: rst_n low while s_req=1 -> s_req, busy, ack all 0 asynchronously; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing one serial transmitter among NUM_REQ byte sources
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, data       per-requester request and packed bytes (requester i at [i*DATA_W +: DATA_W])
//   ack, err        one-cycle pulse to the served requester; err marks a watchdog abort
//   s_req, s_data   request and registered byte towards the transmitter
//   s_ack           transmitter acknowledge (first high cycle in SEND counts)
//   busy, grant_id  high in SEND/GAP; index of the current/last grant
module tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W = 8,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W = 20,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic                      s_req,
    output logic [DATA_W-1:0]         s_data,
    input  logic                      s_ack,
    output logic                      busy,
    output logic [GW-1:0]             grant_id
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t state, state_n;
    logic [GW-1:0] win, grant_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [DATA_W-1:0] s_data_n;
    logic err_n, s_req_n, busy_n, expired;
    // Scan downward in distance so the nearest set bit after grant_id is the last to assign.
    always_comb begin
        win = grant_id;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(grant_id) + k) % NUM_REQ]) win = GW'((int'(grant_id) + k) % NUM_REQ);
    end
    assign expired = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
    always_comb begin
        state_n = state;
        grant_n = grant_id;
        cnt_n = cnt;
        ack_n = '0;
        err_n = 1'b0;
        s_req_n = s_req;
        s_data_n = s_data;
        busy_n = busy;
        case (state)
            IDLE: if (|req) begin
                state_n = SEND;
                grant_n = win;
                s_data_n = data[int'(win)*DATA_W +: DATA_W];
                s_req_n = 1'b1;
                busy_n = 1'b1;
                cnt_n = '0;
            end
            SEND: if (s_ack || expired) begin
                state_n = GAP;
                ack_n = NUM_REQ'(1) << grant_id;
                err_n = !s_ack;
                s_req_n = 1'b0;
            end else cnt_n = cnt + 1'b1;
            GAP: begin
                state_n = IDLE;
                busy_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            grant_id <= GW'(NUM_REQ - 1);
            cnt <= '0;
            ack <= '0;
            err <= 1'b0;
            s_req <= 1'b0;
            s_data <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            grant_id <= grant_n;
            cnt <= cnt_n;
            ack <= ack_n;
            err <= err_n;
            s_req <= s_req_n;
            s_data <= s_data_n;
            busy <= busy_n;
        end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: vector table, directed corner sequences and randomized run against an interval model
module tb_tx_arbiter;
    localparam int N = 2;
    localparam int W = 8;
    localparam int TO = 16;
    localparam int INF = 1 << 30;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] data = '0;
    logic s_ack = 1'b0;
    logic [N-1:0] ack;
    logic err, s_req, busy;
    logic [W-1:0] s_data;
    logic [0:0] grant_id;
    int n_cmp = 0;
    int n_bad = 0;
    tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .err(err),
        .s_req(s_req), .s_data(s_data), .s_ack(s_ack), .busy(busy), .grant_id(grant_id)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] req;
        logic [7:0] d0, d1;
        logic sack, sreq;
        logic [7:0] sdata;
        logic [1:0] ack;
        logic err, busy, gid;
    } vec_t;
    vec_t tbl[26];
    function automatic vec_t v(logic [1:0] r, logic [7:0] d0, logic [7:0] d1, logic sk, logic sr,
                               logic [7:0] sd, logic [1:0] a, logic e, logic b, logic g);
        vec_t x;
        x.req = r; x.d0 = d0; x.d1 = d1; x.sack = sk; x.sreq = sr;
        x.sdata = sd; x.ack = a; x.err = e; x.busy = b; x.gid = g;
        return x;
    endfunction
    task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", t, act, exp, $time);
        end
    endtask
    task automatic chk_out(input string t, input logic sr, input logic [7:0] sd, input logic [1:0] a,
                           input logic e, input logic b, input logic g);
        chk({t, ".s_req"}, 32'(s_req), 32'(sr));
        chk({t, ".s_data"}, 32'(s_data), 32'(sd));
        chk({t, ".ack"}, 32'(ack), 32'(a));
        chk({t, ".err"}, 32'(err), 32'(e));
        chk({t, ".busy"}, 32'(busy), 32'(b));
        chk({t, ".grant_id"}, 32'(grant_id), 32'(g));
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        data = '0;
        s_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    int hi;
    int m_start, m_end, m_gid;
    logic [W-1:0] m_byte;
    logic m_err, found;
    logic [N-1:0] e_ack;
    initial begin
        tbl[0]  = v(2'b01, 8'h1C, 8'h00, 0, 1, 8'h1C, 2'b00, 0, 1, 0);
        tbl[1]  = v(2'b01, 8'h1C, 8'h00, 0, 1, 8'h1C, 2'b00, 0, 1, 0);
        tbl[2]  = v(2'b01, 8'h1C, 8'h00, 0, 1, 8'h1C, 2'b00, 0, 1, 0);
        tbl[3]  = v(2'b01, 8'h1C, 8'h00, 0, 1, 8'h1C, 2'b00, 0, 1, 0);
        tbl[4]  = v(2'b01, 8'h1C, 8'h00, 0, 1, 8'h1C, 2'b00, 0, 1, 0);
        tbl[5]  = v(2'b01, 8'h1C, 8'h00, 1, 0, 8'h1C, 2'b01, 0, 1, 0);
        tbl[6]  = v(2'b00, 8'h1C, 8'h00, 0, 0, 8'h1C, 2'b00, 0, 0, 0);
        tbl[7]  = v(2'b00, 8'h1C, 8'h00, 0, 0, 8'h1C, 2'b00, 0, 0, 0);
        tbl[8]  = v(2'b11, 8'hAA, 8'h55, 0, 1, 8'h55, 2'b00, 0, 1, 1);
        tbl[9]  = v(2'b11, 8'hAA, 8'h55, 1, 0, 8'h55, 2'b10, 0, 1, 1);
        tbl[10] = v(2'b01, 8'hAA, 8'h55, 0, 0, 8'h55, 2'b00, 0, 0, 1);
        tbl[11] = v(2'b11, 8'hAA, 8'h55, 0, 1, 8'hAA, 2'b00, 0, 1, 0);
        tbl[12] = v(2'b11, 8'hAA, 8'h55, 1, 0, 8'hAA, 2'b01, 0, 1, 0);
        tbl[13] = v(2'b10, 8'hAA, 8'h55, 0, 0, 8'hAA, 2'b00, 0, 0, 0);
        tbl[14] = v(2'b11, 8'hAA, 8'h55, 0, 1, 8'h55, 2'b00, 0, 1, 1);
        tbl[15] = v(2'b11, 8'hAA, 8'h55, 1, 0, 8'h55, 2'b10, 0, 1, 1);
        tbl[16] = v(2'b01, 8'hAA, 8'h55, 0, 0, 8'h55, 2'b00, 0, 0, 1);
        tbl[17] = v(2'b11, 8'hAA, 8'h55, 0, 1, 8'hAA, 2'b00, 0, 1, 0);
        tbl[18] = v(2'b11, 8'hAA, 8'h55, 1, 0, 8'hAA, 2'b01, 0, 1, 0);
        tbl[19] = v(2'b00, 8'hAA, 8'h55, 1, 0, 8'hAA, 2'b00, 0, 0, 0);
        tbl[20] = v(2'b00, 8'hAA, 8'h55, 1, 0, 8'hAA, 2'b00, 0, 0, 0);
        tbl[21] = v(2'b01, 8'h3C, 8'h55, 0, 1, 8'h3C, 2'b00, 0, 1, 0);
        tbl[22] = v(2'b01, 8'h3C, 8'h77, 0, 1, 8'h3C, 2'b00, 0, 1, 0);
        tbl[23] = v(2'b00, 8'h99, 8'h77, 0, 1, 8'h3C, 2'b00, 0, 1, 0);
        tbl[24] = v(2'b00, 8'h99, 8'h77, 1, 0, 8'h3C, 2'b01, 0, 1, 0);
        tbl[25] = v(2'b00, 8'h99, 8'h77, 0, 0, 8'h3C, 2'b00, 0, 0, 0);
        do_reset();
        chk_out("reset", 0, 8'h00, 2'b00, 0, 0, 1);
        for (int i = 0; i < 26; i++) begin
            req = tbl[i].req;
            data = {tbl[i].d1, tbl[i].d0};
            s_ack = tbl[i].sack;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].sreq, tbl[i].sdata, tbl[i].ack, tbl[i].err,
                    tbl[i].busy, tbl[i].gid);
        end
        req = 2'b11;
        data = {8'h5A, 8'hA5};
        s_ack = 1'b0;
        @(negedge clk);
        chk_out("to_grant", 1, 8'h5A, 2'b00, 0, 1, 1);
        hi = 0;
        for (int k = 0; k < 40 && s_req === 1'b1; k++) begin
            hi++;
            @(negedge clk);
        end
        chk("to_len", 32'(hi), 32'(TO));
        chk_out("to_abort", 0, 8'h5A, 2'b10, 1, 1, 1);
        req = 2'b01;
        @(negedge clk);
        chk_out("to_gap", 0, 8'h5A, 2'b00, 0, 0, 1);
        @(negedge clk);
        chk_out("to_next", 1, 8'hA5, 2'b00, 0, 1, 0);
        repeat (TO - 1) @(negedge clk);
        chk("co_hold", 32'(s_req), 32'(1));
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        chk_out("co_ack", 0, 8'hA5, 2'b01, 0, 1, 0);
        req = 2'b00;
        do_reset();
        chk_out("rst_state", 0, 8'h00, 2'b00, 0, 0, 1);
        req = 2'b10;
        data = {8'h55, 8'h00};
        @(negedge clk);
        chk_out("first_r1", 1, 8'h55, 2'b00, 0, 1, 1);
        req = 2'b11;
        data = {8'h55, 8'hC3};
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        chk_out("first_r1_ack", 0, 8'h55, 2'b10, 0, 1, 1);
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk_out("then_r0", 1, 8'hC3, 2'b00, 0, 1, 0);
        req = 2'b11;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.s_req", 32'(s_req), 32'(0));
        chk("arst.busy", 32'(busy), 32'(0));
        chk("arst.ack", 32'(ack), 32'(0));
        chk("arst.grant_id", 32'(grant_id), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("post_rst", 1, 8'hC3, 2'b00, 0, 1, 0);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        chk_out("post_rst_ack", 0, 8'hC3, 2'b01, 0, 1, 0);
        req = 2'b00;
        do_reset();
        m_start = -10;
        m_end = -10;
        m_gid = N - 1;
        m_byte = '0;
        m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            e_ack = (c == m_end) ? N'(1 << m_gid) : '0;
            chk("rnd.s_req", 32'(s_req), 32'(c >= m_start && c < m_end));
            chk("rnd.s_data", 32'(s_data), 32'(m_byte));
            chk("rnd.ack", 32'(ack), 32'(e_ack));
            chk("rnd.err", 32'(err), 32'(c == m_end && m_err));
            chk("rnd.busy", 32'(busy), 32'(c >= m_start && c <= m_end));
            chk("rnd.grant_id", 32'(grant_id), 32'(m_gid));
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) req[i] = ($urandom % 4 == 0);
                else if (!req[i]) begin
                    if ($urandom % 3 == 0) begin
                        req[i] = 1'b1;
                        data[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom % 50 == 0) req[i] = 1'b0;
            end
            s_ack = ($urandom % 6 == 0);
            if (c > m_end) begin
                found = 1'b0;
                for (int d = 1; d <= N; d++)
                    if (!found && req[(m_gid + d) % N]) begin
                        found = 1'b1;
                        m_gid = (m_gid + d) % N;
                    end
                if (found) begin
                    m_byte = data[m_gid*W +: W];
                    m_start = c + 1;
                    m_end = INF;
                end
            end else if (m_end == INF && c >= m_start) begin
                if (s_ack) begin
                    m_end = c + 1;
                    m_err = 1'b0;
                end else if (c - m_start == TO - 1) begin
                    m_end = c + 1;
                    m_err = 1'b1;
                end
            end
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
